pmem_responder: RTL and testbench
=================================

# pmem_responder

Line-granular physical-memory responder that sits on the cache's downstream `pmem_*` port and answers 128-bit line reads and writes after a fixed, parameterized latency. It holds a small on-chip line array as backing store. It is the target-side counterpart of the cache's physical-memory initiator and replaces the behavioural memory model in synthesizable system builds.

## Interface
Parameters:
- `IDX_BITS`, default 5: number of line-index bits; the array holds 2^IDX_BITS lines of 16 bytes.
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`; legal range 1..15.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `pmem_read`  in  1: line read request, held by the initiator until `pmem_resp`.
- `pmem_write`  in  1: line write request, held by the initiator until `pmem_resp`.
- `pmem_address`  in  16 (`lc3b_word`): byte address.
- `pmem_wdata`  in  128 (`lc3b_data`): write line.
- `pmem_resp`  out  1: one-cycle completion pulse.
- `pmem_rdata`  out  128 (`lc3b_data`): read line, valid while `pmem_resp`=1.

## Operation
- Line index is `pmem_address[3+IDX_BITS:4]`.
  - Bits [3:0] are ignored (line aligned).
  - Bits above the index are ignored, so addresses alias modulo 2^IDX_BITS lines.
- State machine IDLE → BUSY → RESP → IDLE.
  - **IDLE:** if `pmem_read` or `pmem_write` is 1 at a clock edge, accept the request.
    - Latch op, index and `pmem_wdata`; load the counter with LATENCY-1.
    - If LATENCY=1, go to RESP; otherwise go to BUSY.
  - **BUSY:** decrement the counter each edge; at counter=1, go to RESP.
    - Input changes are ignored, including deassertion of the request. The transaction still completes.
  - **RESP:** `pmem_resp`=1 for exactly this one cycle, then go to IDLE.
- Both `pmem_read` and `pmem_write` high at acceptance: write takes priority, and `pmem_rdata` is not updated.
- Write commit: the array line is written with the latched data on the edge entering RESP.
- Read capture: `pmem_rdata` is loaded from the array on the edge entering RESP and holds its value until the next read enters RESP. Writes do not change it.
- Back-to-back: a request present in the cycle after RESP is accepted normally; there is no turnaround cycle.
- Array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset values: state=IDLE, counter=0, `pmem_resp`=0, `pmem_rdata`=128'h0. The latched op, index and data registers are cleared.
- Reset asserted mid-transaction: the transaction is aborted.
  - No `pmem_resp` is produced.
  - A pending write is not committed; the array is unchanged.
- Latency: request accepted at edge E0 means `pmem_resp` is high during the cycle after edge E0+LATENCY-1. That is exactly LATENCY cycles after the accepting edge.
- Throughput: one transaction per LATENCY+1 cycles (accept, LATENCY-1 busy cycles, resp).
- All outputs are registered; there is no combinational path from input to output.
- Read-after-write to the same line, issued back-to-back, returns the new data. The write commits before the read is accepted.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → `pmem_resp`=0 and `pmem_rdata`=0 immediately. After release, the block is idle with no spurious resp.
- **Write then read, LATENCY=4:**
  - Write 0x0123...CDEF to address 0x0040 → `pmem_resp` is high exactly 4 cycles after acceptance, for one cycle.
  - Read 0x0040 → resp 4 cycles after acceptance with the same data.
- **Aliasing and ignored offset, IDX_BITS=5:**
  - Write 0xAAAA.. to 0x0200 (line 0), then read 0x000F → returns 0xAAAA...
  - Read 0x0210 → returns the contents of line 1, not 0xAAAA...
- **Simultaneous read+write:** assert both with address 0x0080 and wdata 0x5555.. → one resp; `pmem_rdata` keeps its previous value. A subsequent read of 0x0080 returns 0x5555...
- **Mid-flight changes:**
  - Change `pmem_address` during BUSY → the originally latched address is used.
  - Drop `pmem_read` in BUSY → resp still pulses once.
  - Reset during a BUSY write to 0x0100 → no resp, and line 0x0100 keeps its old data.
- **LATENCY=1 back-to-back:** 8 consecutive reads held continuously → resp pulses every 2 cycles, each carrying the correct line data.

Source files
------------

// File: rtl/pmem_responder.sv
// pmem_responder: line-granular backing store answering 128-bit pmem reads/writes after LATENCY cycles.
module pmem_responder #(
  parameter int IDX_BITS = 5,
  parameter int LATENCY  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [127:0]         wdata_q, wdata_d;
  logic [127:0]         rdata_q, rdata_d;
  logic                 resp_q, resp_d;
  logic [127:0]         mem [2**IDX_BITS];
  logic                 go_resp, c_we;
  logic [IDX_BITS-1:0]  c_idx;
  logic [127:0]         c_data;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (pmem_read || pmem_write) begin
        we_d    = pmem_write;
        idx_d   = pmem_address[3+IDX_BITS:4];
        wdata_d = pmem_wdata;
        cnt_d   = LAT_M1;
        go_resp = (LATENCY == 1);
        state_d = go_resp ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d   = cnt_q - 4'd1;
        go_resp = (cnt_q == 4'd1);
        state_d = go_resp ? RESP : BUSY;
      end
      default: state_d = IDLE;
    endcase
    // with LATENCY=1 the commit happens on the accepting edge, so use the live inputs
    c_we    = (state_q == IDLE) ? pmem_write : we_q;
    c_idx   = (state_q == IDLE) ? pmem_address[3+IDX_BITS:4] : idx_q;
    c_data  = (state_q == IDLE) ? pmem_wdata : wdata_q;
    resp_d  = go_resp;
    rdata_d = (go_resp && !c_we) ? mem[c_idx] : rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (go_resp && c_we) mem[c_idx] <= c_data;
  end
  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: scoreboard bench for LATENCY=4 and LATENCY=1 instances.
module tb_pmem_responder;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rd [2];
  logic         wr [2];
  logic [15:0]  addr [2];
  logic [127:0] wd [2];
  logic         resp [2];
  logic [127:0] rdata [2];
  typedef struct {bit is_rd; logic [127:0] data; int due;} exp_t;
  exp_t         sb [2][$];
  logic [127:0] mdl [2][32];
  logic [127:0] lastr [2];
  bit           jr [2];
  int           cyc = 0, checks = 0, errors = 0;

  pmem_responder #(.IDX_BITS(5), .LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]), .pmem_rdata(rdata[0]));
  pmem_responder #(.IDX_BITS(5), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]), .pmem_rdata(rdata[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [127:0] x;
    if (reset) begin
      lastr[0] = '0;
      lastr[1] = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (resp[k]) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL spurious_resp inst%0d cyc %0d got resp=1 want 0", k, cyc);
          end else begin
            e = sb[k].pop_front();
            x = e.is_rd ? e.data : lastr[k];
            if (e.due != cyc) begin
              errors++;
              $display("FAIL resp_time inst%0d got cyc %0d want cyc %0d", k, cyc, e.due);
            end
            checks++;
            if (rdata[k] !== x) begin
              errors++;
              $display("FAIL rdata inst%0d cyc %0d got %h want %h", k, cyc, rdata[k], x);
            end
            lastr[k] = x;
          end
        end else if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_resp inst%0d cyc %0d got resp=0 want 1", k, cyc);
        end
      end
    end
  end

  task automatic chk(string n, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask

  // mut: 0 none, 1 scramble address while busy, 2 drop the request while busy
  task automatic xact(int k, bit r, bit w, logic [15:0] a, logic [127:0] d, int mut);
    exp_t e;
    bit got;
    e.due = cyc + (jr[k] ? 2 : 1) + lat(k) - 1;
    e.is_rd = !w;
    e.data = mdl[k][a[8:4]];
    if (w) mdl[k][a[8:4]] = d;
    sb[k].push_back(e);
    rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
    got = 1'b0;
    for (int i = 0; i < lat(k) + 6 && !got; i++) begin
      @(negedge clk);
      if (i == 1 && mut == 1) addr[k] = 16'($urandom);
      if (i == 1 && mut == 2) begin rd[k] = 1'b0; wr[k] = 1'b0; end
      got = resp[k];
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d addr %h got no resp want resp", k, a);
    end
    jr[k] = got;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < 2; k++) begin rd[k] = 1'b0; wr[k] = 1'b0; end
    repeat (n) @(negedge clk);
    jr[0] = 1'b0;
    jr[1] = 1'b0;
  endtask

  initial begin
    logic [127:0] old;
    int op;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0; jr[k] = 1'b0;
    end
    #3 reset = 1'b1;
    #1;
    chk("reset_resp0", 128'(resp[0]), 128'h0);
    chk("reset_resp1", 128'(resp[1]), 128'h0);
    chk("reset_rdata0", rdata[0], 128'h0);
    chk("reset_rdata1", rdata[1], 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++)
        xact(k, 1'b0, 1'b1, 16'(i << 4), {$urandom, $urandom, $urandom, $urandom}, 0);
      idle(2);
    end
    xact(0, 1'b0, 1'b1, 16'h0040, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    xact(0, 1'b1, 1'b0, 16'h0040, '0, 0);
    xact(0, 1'b0, 1'b1, 16'h0200, {8{16'hAAAA}}, 0);
    xact(0, 1'b1, 1'b0, 16'h000F, '0, 0);
    xact(0, 1'b1, 1'b0, 16'h0210, '0, 0);
    xact(0, 1'b1, 1'b1, 16'h0080, {8{16'h5555}}, 0);
    xact(0, 1'b1, 1'b0, 16'h0080, '0, 0);
    idle(2);
    xact(0, 1'b1, 1'b0, 16'h0040, '0, 1);
    idle(1);
    xact(0, 1'b1, 1'b0, 16'h0210, '0, 2);
    idle(3);
    old = mdl[0][16];
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0100; wd[0] = ~old;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_resp", 128'(resp[0]), 128'h0);
    chk("midreset_rdata0", rdata[0], 128'h0);
    chk("midreset_rdata1", rdata[1], 128'h0);
    wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    xact(0, 1'b1, 1'b0, 16'h0100, '0, 0);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        op = $urandom_range(0, 2);
        xact(k, op != 1, op != 0, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);
    end
    for (int i = 0; i < 8; i++) xact(1, 1'b1, 1'b0, 16'(i * 16 + 3), '0, 0);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
